// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite definitions for the interconnect slice.
//   htrans_t   : HTRANS encodings
//   HRESP_*    : response codes driven on HRESP
//   ds_state_t : default-slave response FSM states
//   htrans_active() : true for transfers that carry data (NONSEQ/SEQ)
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  function automatic logic htrans_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: answers transfers that hit no slave. Active transfers
// get the two-cycle ERROR response and are logged; IDLE/BUSY get zero-wait
// OKAY.
//   HCLK, HRESETn : clock, async active-low reset
//   sel           : address phase targets no mapped slave
//   HTRANS, HADDR : master address phase
//   HREADY        : global bus ready (address phase accepted when 1)
//   ERR_CLR       : clears ERR_VALID and ERR_CNT
//   HREADYOUT, HRESP : default-slave response (registered)
//   ERR_VALID, ERR_ADDR, ERR_CNT : error log
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              sel,
  input  logic [1:0]        HTRANS,
  input  logic              HREADY,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              ERR_CLR,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              ERR_VALID,
  output logic [ADDR_W-1:0] ERR_ADDR,
  output logic [CNT_W-1:0]  ERR_CNT
);

  ds_state_t state;
  logic      new_err;

  // A new error starts only when an address phase is accepted; ERR1 always
  // holds HREADY low, so the state term just makes that explicit.
  assign new_err = HREADY && sel && htrans_active(HTRANS) && (state != DS_ERR1);

  // NOTE: the reset branch is asynchronous (in the sensitivity list) so that
  // HRESETn clears an in-flight ERROR response without waiting for a clock.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= DS_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values, independent of statement order.
      case (state)
        DS_IDLE, DS_ERR2: begin
          if (new_err) begin
            state     <= DS_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
          end else if (HREADY) begin
            state     <= DS_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end
        end
        DS_ERR1: begin
          state     <= DS_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: begin
          state     <= DS_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Error log. A new error outranks a simultaneous clear, so the count
  // restarts at one rather than zero.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ERR_VALID <= 1'b0;
      ERR_ADDR  <= '0;
      ERR_CNT   <= '0;
    end else if (new_err) begin
      ERR_VALID <= 1'b1;
      ERR_ADDR  <= HADDR;
      if (ERR_CLR)
        ERR_CNT <= CNT_W'(1);
      else if (ERR_CNT != '1)
        ERR_CNT <= ERR_CNT + CNT_W'(1);
    end else if (ERR_CLR) begin
      ERR_VALID <= 1'b0;
      ERR_CNT   <= '0;
    end
  end

endmodule

// File: rtl/ahb_lite_decoder_mux.sv
// ahb_lite_decoder_mux: single-master AHB-Lite address decoder and response
// multiplexer with an integrated error-logging default slave.
//   HCLK, HRESETn        : clock, async active-low reset
//   HADDR, HTRANS        : master address phase
//   HSELx                : one-hot slave select, combinational from HADDR
//   HRDATA_S, HREADYOUT_S, HRESP_S : packed slave responses
//   HRDATA, HREADY, HRESP          : muxed response to master (and HREADY
//                                    to all slaves)
//   ERR_CLR, ERR_VALID, ERR_ADDR, ERR_CNT : unmapped-access log
module ahb_lite_decoder_mux
  import ahb_pkg::*;
#(
  parameter int                             NUM_SLAVES = 4,
  parameter int                             ADDR_W     = 32,
  parameter int                             DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_START  = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_END    = '1,
  parameter int                             CNT_W      = 8
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [NUM_SLAVES-1:0]        HSELx,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  input  logic                         ERR_CLR,
  output logic                         ERR_VALID,
  output logic [ADDR_W-1:0]            ERR_ADDR,
  output logic [CNT_W-1:0]             ERR_CNT
);

  // Data-phase select: slave index 0..NUM_SLAVES-1, or SEL_DEFAULT.
  localparam int               SEL_W       = $clog2(NUM_SLAVES + 1);
  localparam logic [SEL_W-1:0] SEL_DEFAULT = SEL_W'(NUM_SLAVES);

  logic [NUM_SLAVES-1:0] hit;
  logic [SEL_W-1:0]      dec_idx;
  logic [SEL_W-1:0]      dsel;
  logic                  ds_hready;
  logic                  ds_hresp;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_dec
    assign hit[i] = (HADDR >= SLV_START[i*ADDR_W +: ADDR_W]) &&
                    (HADDR <= SLV_END[i*ADDR_W +: ADDR_W]);
  end

  // Isolate the lowest set bit so overlapping regions resolve to the lowest
  // index; an empty hit vector stays zero.
  assign HSELx = hit & ~(hit - NUM_SLAVES'(1));

  // NOTE: always_comb outputs get a default before any conditional update so
  // no path leaves them unassigned (no latch).
  always_comb begin
    dec_idx = SEL_DEFAULT;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) dec_idx = SEL_W'(i);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      dsel <= SEL_DEFAULT;
    else if (HREADY)
      dsel <= dec_idx;
  end

  ahb_default_slave #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .sel       (~|hit),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HADDR     (HADDR),
    .ERR_CLR   (ERR_CLR),
    .HREADYOUT (ds_hready),
    .HRESP     (ds_hresp),
    .ERR_VALID (ERR_VALID),
    .ERR_ADDR  (ERR_ADDR),
    .ERR_CNT   (ERR_CNT)
  );

  // Slave-to-master path is purely combinational.
  always_comb begin
    HRDATA = '0;
    HREADY = ds_hready;
    HRESP  = ds_hresp;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel == SEL_W'(i)) begin
        HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// Self-checking bench for ahb_lite_decoder_mux: a transaction-level model
// (which slave owns the data phase, how far into an ERROR response we are,
// and the error log) predicts every output each cycle; literal checks pin
// the model on the hand-worked cases.
module tb_ahb_lite_decoder_mux;
  import ahb_pkg::*;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int CNT_MAX = 255;

  localparam logic [NS*AW-1:0] MAP_START =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MAP_END =
    {32'h3FFF_FFFF, 32'h2FFF_FFFF, 32'h1FFF_FFFF, 32'h0FFF_FFFF};
  // Overlap map: slave 0 and slave 2 both cover 0x2000_0000.
  localparam logic [NS*AW-1:0] OVL_START =
    {32'h3000_0000, 32'h2000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] OVL_END =
    {32'h3FFF_FFFF, 32'h2FFF_FFFF, 32'h4FFF_FFFF, 32'h2FFF_FFFF};

  // Model's view of the map, lowest index first.
  int unsigned lo_tab [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
  int unsigned hi_tab [NS] = '{32'h0FFF_FFFF, 32'h1FFF_FFFF, 32'h2FFF_FFFF, 32'h3FFF_FFFF};

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic [AW-1:0]    HADDR;
  logic [1:0]       HTRANS;
  logic [NS-1:0]    HSELx;
  logic [NS*DW-1:0] HRDATA_S;
  logic [NS-1:0]    HREADYOUT_S;
  logic [NS-1:0]    HRESP_S;
  logic [DW-1:0]    HRDATA;
  logic             HREADY;
  logic             HRESP;
  logic             ERR_CLR;
  logic             ERR_VALID;
  logic [AW-1:0]    ERR_ADDR;
  logic [CW-1:0]    ERR_CNT;

  logic [NS-1:0]    hsel2;
  logic [DW-1:0]    hrdata2;
  logic             hready2, hresp2, err_valid2;
  logic [AW-1:0]    err_addr2;
  logic [CW-1:0]    err_cnt2;
  logic [NS*DW-1:0] tie_data = '0;
  logic [NS-1:0]    tie_ready = '1;
  logic [NS-1:0]    tie_resp = '0;
  logic             tie_clr = 1'b0;

  ahb_lite_decoder_mux #(
    .NUM_SLAVES (NS), .ADDR_W (AW), .DATA_W (DW),
    .SLV_START (MAP_START), .SLV_END (MAP_END), .CNT_W (CW)
  ) dut (
    .HCLK (HCLK), .HRESETn (HRESETn), .HADDR (HADDR), .HTRANS (HTRANS),
    .HSELx (HSELx), .HRDATA_S (HRDATA_S), .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S (HRESP_S), .HRDATA (HRDATA), .HREADY (HREADY), .HRESP (HRESP),
    .ERR_CLR (ERR_CLR), .ERR_VALID (ERR_VALID), .ERR_ADDR (ERR_ADDR),
    .ERR_CNT (ERR_CNT)
  );

  ahb_lite_decoder_mux #(
    .NUM_SLAVES (NS), .ADDR_W (AW), .DATA_W (DW),
    .SLV_START (OVL_START), .SLV_END (OVL_END), .CNT_W (CW)
  ) dut_ovl (
    .HCLK (HCLK), .HRESETn (HRESETn), .HADDR (HADDR), .HTRANS (HTRANS),
    .HSELx (hsel2), .HRDATA_S (tie_data), .HREADYOUT_S (tie_ready),
    .HRESP_S (tie_resp), .HRDATA (hrdata2), .HREADY (hready2), .HRESP (hresp2),
    .ERR_CLR (tie_clr), .ERR_VALID (err_valid2), .ERR_ADDR (err_addr2),
    .ERR_CNT (err_cnt2)
  );

  int n_vec = 0;
  int n_err = 0;

  // Slave stimulus for the next cycle; applied at the negedge by apply().
  logic [NS-1:0]    nx_ready;
  logic [NS-1:0]    nx_resp;
  logic [NS*DW-1:0] nx_data;

  // Model state.
  int          dp_slave;    // -1: default slave owns the data phase
  int          err_phase;   // 0: none, 1: first ERROR cycle, 2: second
  bit          m_valid;
  logic [31:0] m_addr;
  int          m_cnt;
  bit          exp_ready_last;
  bit          pend;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (a >= lo_tab[i] && a <= hi_tab[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    dp_slave  = -1;
    err_phase = 0;
    m_valid   = 0;
    m_addr    = '0;
    m_cnt     = 0;
  endtask

  task automatic model_compare();
    int          d;
    logic [3:0]  eh;
    logic        er, es;
    logic [31:0] ed;
    d  = decode(HADDR);
    eh = (d >= 0) ? 4'(1 << d) : 4'b0000;
    if (dp_slave >= 0) begin
      er = HREADYOUT_S[dp_slave];
      es = HRESP_S[dp_slave];
      ed = HRDATA_S[dp_slave*DW +: DW];
    end else begin
      er = (err_phase != 1);
      es = (err_phase != 0);
      ed = '0;
    end
    check("hsel", 64'(HSELx), 64'(eh));
    check("hready", 64'(HREADY), 64'(er));
    check("hresp", 64'(HRESP), 64'(es));
    check("hrdata", 64'(HRDATA), 64'(ed));
    check("err_valid", 64'(ERR_VALID), 64'(m_valid));
    check("err_addr", 64'(ERR_ADDR), 64'(m_addr));
    check("err_cnt", 64'(ERR_CNT), 64'(m_cnt));
    exp_ready_last = er;
  endtask

  // Advance the model across the clock edge using the inputs held this cycle.
  task automatic model_commit();
    int d;
    bit new_err;
    new_err = 0;
    if (exp_ready_last) begin
      d = decode(HADDR);
      if (d >= 0) begin
        dp_slave  = d;
        err_phase = 0;
      end else begin
        dp_slave  = -1;
        new_err   = HTRANS[1];
        err_phase = new_err ? 1 : 0;
      end
    end else if (dp_slave < 0 && err_phase == 1) begin
      err_phase = 2;
    end
    if (new_err) begin
      m_valid = 1;
      m_addr  = HADDR;
      m_cnt   = ERR_CLR ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
    end else if (ERR_CLR) begin
      m_valid = 0;
      m_cnt   = 0;
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [1:0] t, input logic clr = 1'b0);
    if (pend) model_commit();
    @(negedge HCLK);
    HADDR       = a;
    HTRANS      = t;
    ERR_CLR     = clr;
    HREADYOUT_S = nx_ready;
    HRESP_S     = nx_resp;
    HRDATA_S    = nx_data;
    #2;
    model_compare();
    pend = 1;
  endtask

  task automatic release_reset();
    @(negedge HCLK);
    HRESETn        = 1'b1;
    exp_ready_last = 1'b1;
    pend           = 1;
  endtask

  function automatic logic [31:0] rand_unmapped();
    logic [31:0] a;
    a = $urandom;
    if (a < 32'h4000_0000) a = a + 32'h4000_0000;
    return a;
  endfunction

  initial begin
    logic [31:0] sweep_a [4] = '{32'h0FFF_FFFF, 32'h1000_0000, 32'h3FFF_FFFF, 32'h4000_0000};
    logic [3:0]  sweep_h [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0000};
    logic [31:0] ua;

    HRESETn     = 1'b0;
    HADDR       = '0;
    HTRANS      = HTRANS_IDLE;
    ERR_CLR     = 1'b0;
    nx_ready    = '1;
    nx_resp     = '0;
    nx_data     = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0001};
    HREADYOUT_S = nx_ready;
    HRESP_S     = nx_resp;
    HRDATA_S    = nx_data;
    pend        = 0;
    model_reset();

    // Reset values.
    repeat (2) @(negedge HCLK);
    #2;
    check("rst_hready", 64'(HREADY), 64'd1);
    check("rst_hresp", 64'(HRESP), 64'd0);
    check("rst_hrdata", 64'(HRDATA), 64'd0);
    check("rst_err_valid", 64'(ERR_VALID), 64'd0);
    check("rst_err_cnt", 64'(ERR_CNT), 64'd0);
    check("rst_err_addr", 64'(ERR_ADDR), 64'd0);
    release_reset();

    // Decode sweep at region boundaries.
    for (int i = 0; i < 4; i++) begin
      apply(sweep_a[i], HTRANS_IDLE);
      check("lit_hsel_sweep", 64'(HSELx), 64'(sweep_h[i]));
    end

    // Slave 1 with two wait states.
    apply(32'h1000_0004, HTRANS_NONSEQ);
    nx_data[63:32] = 32'hCAFE_F00D;
    nx_ready = 4'b1101;
    apply(32'h1000_0004, HTRANS_IDLE);
    check("lit_wait1_hready", 64'(HREADY), 64'd0);
    apply(32'h1000_0004, HTRANS_IDLE);
    check("lit_wait2_hready", 64'(HREADY), 64'd0);
    nx_ready = 4'b1111;
    apply(32'h1000_0004, HTRANS_IDLE);
    check("lit_wait3_hready", 64'(HREADY), 64'd1);
    check("lit_wait3_hrdata", 64'(HRDATA), 64'hCAFE_F00D);
    check("lit_wait3_hresp", 64'(HRESP), 64'd0);

    // Unmapped NONSEQ: two-cycle ERROR and a log entry.
    apply(32'h5000_0000, HTRANS_NONSEQ);
    apply(32'h5000_0000, HTRANS_NONSEQ);
    check("lit_err1_hready", 64'(HREADY), 64'd0);
    check("lit_err1_hresp", 64'(HRESP), 64'd1);
    check("lit_err_valid", 64'(ERR_VALID), 64'd1);
    check("lit_err_addr", 64'(ERR_ADDR), 64'h5000_0000);
    check("lit_err_cnt", 64'(ERR_CNT), 64'd1);
    apply(32'h0000_0000, HTRANS_IDLE);
    check("lit_err2_hready", 64'(HREADY), 64'd1);
    check("lit_err2_hresp", 64'(HRESP), 64'd1);

    // IDLE to unmapped: zero-wait OKAY, not logged.
    apply(32'h5000_0000, HTRANS_IDLE);
    apply(32'h0000_0000, HTRANS_IDLE);
    check("lit_idle_unmapped_hready", 64'(HREADY), 64'd1);
    check("lit_idle_unmapped_hresp", 64'(HRESP), 64'd0);
    check("lit_idle_unmapped_cnt", 64'(ERR_CNT), 64'd1);

    // 300 back-to-back unmapped NONSEQ: each occupies an address cycle and
    // the following ERR1 cycle during which the address is held.
    for (int k = 0; k < 300; k++) begin
      ua = rand_unmapped();
      apply(ua, HTRANS_NONSEQ);
      apply(ua, HTRANS_NONSEQ);
    end
    check("lit_cnt_saturated", 64'(ERR_CNT), 64'd255);
    // Now in ERR2: the clear coincides with a new error.
    apply(32'h7000_0010, HTRANS_SEQ, 1'b1);
    apply(32'h7000_0010, HTRANS_IDLE);
    check("lit_clr_vs_err_cnt", 64'(ERR_CNT), 64'd1);
    check("lit_clr_vs_err_valid", 64'(ERR_VALID), 64'd1);
    check("lit_clr_vs_err_addr", 64'(ERR_ADDR), 64'h7000_0010);
    apply(32'h0000_0000, HTRANS_IDLE, 1'b1);
    apply(32'h0000_0000, HTRANS_IDLE);
    check("lit_clr_cnt", 64'(ERR_CNT), 64'd0);
    check("lit_clr_valid", 64'(ERR_VALID), 64'd0);

    // Overlapping map resolves to the lowest index.
    apply(32'h2000_0000, HTRANS_IDLE);
    check("lit_overlap_hsel", 64'(hsel2), 64'b0001);

    // Randomised traffic with wait states, slave errors and log clears.
    for (int k = 0; k < 600; k++) begin
      nx_ready = 4'($urandom) | 4'($urandom);
      nx_resp  = 4'($urandom);
      nx_data  = {$urandom, $urandom, $urandom, $urandom};
      apply({4'($urandom_range(0, 5)), 28'($urandom)}, 2'($urandom),
            ($urandom_range(0, 19) == 0));
    end

    // Reset asserted during ERR1 clears everything immediately.
    nx_ready = '1;
    nx_resp  = '0;
    apply(32'h0000_0000, HTRANS_IDLE);
    apply(32'h0000_0000, HTRANS_IDLE);
    apply(32'h6000_0000, HTRANS_NONSEQ);
    apply(32'h6000_0000, HTRANS_NONSEQ);
    check("lit_pre_rst_hready", 64'(HREADY), 64'd0);
    #1 HRESETn = 1'b0;
    #1;
    check("lit_async_rst_hready", 64'(HREADY), 64'd1);
    check("lit_async_rst_hresp", 64'(HRESP), 64'd0);
    check("lit_async_rst_valid", 64'(ERR_VALID), 64'd0);
    check("lit_async_rst_cnt", 64'(ERR_CNT), 64'd0);
    check("lit_async_rst_addr", 64'(ERR_ADDR), 64'd0);
    model_reset();
    pend = 0;
    release_reset();
    for (int k = 0; k < 4; k++)
      apply(32'h3000_0000 + 32'(k), HTRANS_NONSEQ);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
